quantum_timer: RTL and testbench

//  Preemption quantum timer for the single-cycle core. Counts retired instructions

---
 rtl/quantum_timer_pkg.sv | 13 +
 rtl/quantum_timer_if.sv | 30 +++
 rtl/quantum_timer.sv | 95 +++++++++
 tb/tb_quantum_timer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/quantum_timer_pkg.sv
// Shared constants for the preemption quantum timer: state encoding and default quantum.
// The decoder and interrupt-return logic import the same encoding.
package quantum_timer_pkg;

  typedef enum logic [1:0] {
    QT_IDLE = 2'd0,
    QT_RUN  = 2'd1,
    QT_FIRE = 2'd2
  } qt_state_e;

  localparam int QT_DEFAULT_QUANTUM = 100;

endpackage

// File: rtl/quantum_timer_if.sv
// Signal bundle between the core control path (master) and the quantum timer (slave).
// Handshake: strobes and retire inputs are sampled on every rising clk edge; no back-pressure.
interface quantum_timer_if #(
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 32
);
  import quantum_timer_pkg::*;

  logic              stopQnt;
  logic              rstQnt;
  logic              halt;
  logic              instr_valid;
  logic [ADDR_W-1:0] pc_next;
  logic              intSig;
  logic [ADDR_W-1:0] int_ret_addr;
  logic              qnt_running;
  logic [CNT_W-1:0]  count;
  qt_state_e         dbg_state;

  modport master (
    output stopQnt, rstQnt, halt, instr_valid, pc_next,
    input  intSig, int_ret_addr, qnt_running, count, dbg_state
  );

  modport slave (
    input  stopQnt, rstQnt, halt, instr_valid, pc_next,
    output intSig, int_ret_addr, qnt_running, count, dbg_state
  );

endinterface

// File: rtl/quantum_timer.sv
// Counts retired instructions while armed and raises intSig for one (or more, if halted)
// cycles when the quantum expires, latching the resume PC for the OS handler.
module quantum_timer
  import quantum_timer_pkg::*;
#(
  parameter int QUANTUM = QT_DEFAULT_QUANTUM,
  parameter int CNT_W   = 16,
  parameter int ADDR_W  = 32
) (
  input logic           clk,
  input logic           rst,
  quantum_timer_if.slave qif
);

  if (QUANTUM < 1 || longint'(QUANTUM) >= (longint'(1) << CNT_W)) begin : g_bad_quantum
    $error("quantum_timer: QUANTUM must be in 1..2**CNT_W-1");
  end

  localparam logic [CNT_W-1:0] LAST = CNT_W'(QUANTUM - 1);

  qt_state_e         state_q, state_n;
  logic [CNT_W-1:0]  count_q, count_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              rearm_q, rearm_n;
  logic              ret;

  assign ret = qif.instr_valid & ~qif.halt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= QT_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      rearm_q <= 1'b0;
    end else begin
      state_q <= state_n;
      count_q <= count_n;
      addr_q  <= addr_n;
      rearm_q <= rearm_n;
    end
  end

  always_comb begin
    state_n = state_q;
    count_n = count_q;
    addr_n  = addr_q;
    rearm_n = rearm_q;
    case (state_q)
      QT_IDLE: begin
        if (qif.rstQnt) begin
          count_n = '0;
          if (!qif.stopQnt) state_n = QT_RUN;
        end
      end
      QT_RUN: begin
        // Strobes take priority over an expiring retire: stop wins, clear still applies.
        if (qif.stopQnt) begin
          state_n = QT_IDLE;
          if (qif.rstQnt) count_n = '0;
        end else if (qif.rstQnt) begin
          count_n = '0;
        end else if (ret) begin
          if (count_q == LAST) begin
            count_n = '0;
            addr_n  = qif.pc_next;
            state_n = QT_FIRE;
          end else begin
            count_n = count_q + CNT_W'(1);
          end
        end
      end
      QT_FIRE: begin
        // stopQnt is ignored here: the decoder's interrupt path raises it alongside intSig.
        if (qif.rstQnt) rearm_n = 1'b1;
        if (!qif.halt) begin
          rearm_n = 1'b0;
          count_n = '0;
          state_n = (rearm_q || qif.rstQnt) ? QT_RUN : QT_IDLE;
        end
      end
      default: begin
        state_n = QT_IDLE;
        count_n = '0;
        rearm_n = 1'b0;
      end
    endcase
  end

  assign qif.intSig       = (state_q == QT_FIRE);
  assign qif.qnt_running  = (state_q == QT_RUN);
  assign qif.count        = count_q;
  assign qif.int_ret_addr = addr_q;
  assign qif.dbg_state    = state_q;

endmodule

// File: tb/tb_quantum_timer.sv
// Bench for quantum_timer: a QUANTUM=100 instance for the main sequences and a
// QUANTUM=1 instance for the degenerate quantum.
module tb_quantum_timer;
  import quantum_timer_pkg::*;

  localparam int CNT_W  = 16;
  localparam int ADDR_W = 32;
  localparam int EXP_W  = 2 + 1 + 1 + CNT_W + ADDR_W;

  logic clk;
  logic rst;

  quantum_timer_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) ifa ();
  quantum_timer_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) ifb ();

  quantum_timer #(.QUANTUM(100), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut_a (
    .clk (clk),
    .rst (rst),
    .qif (ifa)
  );

  quantum_timer #(.QUANTUM(1), .CNT_W(CNT_W), .ADDR_W(ADDR_W)) dut_b (
    .clk (clk),
    .rst (rst),
    .qif (ifb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [EXP_W-1:0] exp_q[$];
  string            name_q[$];
  logic [ADDR_W-1:0] a_addr;

  typedef struct {
    bit              stop;
    bit              rq;
    bit              h;
    bit              iv;
    logic [CNT_W-1:0] ecnt;
    bit              erun;
  } vec_t;

  function automatic logic [EXP_W-1:0] pack(bit ei, bit er, logic [CNT_W-1:0] ec, logic [ADDR_W-1:0] ea);
    logic [1:0] st;
    st = ei ? 2'd2 : (er ? 2'd1 : 2'd0);
    return {st, ei, er, ec, ea};
  endfunction

  function automatic logic [EXP_W-1:0] sample(bit sel);
    if (sel)
      return {ifb.dbg_state, ifb.intSig, ifb.qnt_running, ifb.count, ifb.int_ret_addr};
    return {ifa.dbg_state, ifa.intSig, ifa.qnt_running, ifa.count, ifa.int_ret_addr};
  endfunction

  task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%0d int=%0b run=%0b cnt=%0d addr=%h, want st=%0d int=%0b run=%0b cnt=%0d addr=%h",
               name, act[EXP_W-1 -: 2], act[EXP_W-3], act[EXP_W-4], act[ADDR_W +: CNT_W], act[ADDR_W-1:0],
               exp[EXP_W-1 -: 2], exp[EXP_W-3], exp[EXP_W-4], exp[ADDR_W +: CNT_W], exp[ADDR_W-1:0]);
    end
  endtask

  // driver: apply one cycle of inputs to the selected instance, then score after the edge
  task automatic step(input string name, input bit sel, input bit stop, input bit rq, input bit h,
                      input bit iv, input logic [ADDR_W-1:0] pc,
                      input bit ei, input bit er, input logic [CNT_W-1:0] ec, input logic [ADDR_W-1:0] ea);
    logic [EXP_W-1:0] e;
    string            nm;
    @(negedge clk);
    ifa.stopQnt = sel ? 1'b0 : stop;
    ifa.rstQnt  = sel ? 1'b0 : rq;
    ifa.halt    = sel ? 1'b0 : h;
    ifa.instr_valid = sel ? 1'b0 : iv;
    ifa.pc_next = pc;
    ifb.stopQnt = sel ? stop : 1'b0;
    ifb.rstQnt  = sel ? rq : 1'b0;
    ifb.halt    = sel ? h : 1'b0;
    ifb.instr_valid = sel ? iv : 1'b0;
    ifb.pc_next = pc;
    exp_q.push_back(pack(ei, er, ec, ea));
    name_q.push_back(name);
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    check(nm, sample(sel), e);
  endtask

  task automatic retire_n(input string name, input int n, input logic [CNT_W-1:0] start, input bit hold);
    for (int i = 1; i <= n; i++)
      step(name, 0, 0, 0, 0, 1, ADDR_W'(i), 0, 1, hold ? start : CNT_W'(start + CNT_W'(i)), a_addr);
  endtask

  vec_t vecs[11];

  initial begin
    ifa.stopQnt = 0; ifa.rstQnt = 0; ifa.halt = 0; ifa.instr_valid = 0; ifa.pc_next = '0;
    ifb.stopQnt = 0; ifb.rstQnt = 0; ifb.halt = 0; ifb.instr_valid = 0; ifb.pc_next = '0;
    a_addr = '0;
    rst = 1'b1;
    #12;
    check("reset_a", sample(0), pack(0, 0, 0, 0));
    check("reset_b", sample(1), pack(0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;

    // 1: full quantum expires, intSig exactly one cycle after the 100th retire
    step("t1_arm", 0, 0, 1, 0, 0, 0, 0, 1, 0, a_addr);
    retire_n("t1_ret", 99, 0, 0);
    a_addr = 32'h40;
    step("t1_expire", 0, 0, 0, 0, 1, 32'h40, 1, 0, 0, a_addr);
    step("t1_after", 0, 0, 0, 0, 0, 0, 0, 0, 0, a_addr);
    step("t1_idle", 0, 0, 0, 0, 1, 0, 0, 0, 0, a_addr);

    // 2: stop holds count, retires ignored while disarmed
    step("t2_arm", 0, 0, 1, 0, 0, 0, 0, 1, 0, a_addr);
    retire_n("t2_ret", 50, 0, 0);
    step("t2_stop", 0, 1, 0, 0, 0, 0, 0, 0, 50, a_addr);
    for (int i = 0; i < 30; i++)
      step("t2_held", 0, 0, 0, 0, 1, 0, 0, 0, 50, a_addr);
    step("t2_rearm", 0, 0, 1, 0, 0, 0, 0, 1, 0, a_addr);

    // 3: halt blocks retirement
    retire_n("t3_ret", 99, 0, 0);
    for (int i = 0; i < 5; i++)
      step("t3_halt", 0, 0, 0, 1, 1, 0, 0, 1, 99, a_addr);
    a_addr = 32'h80;
    step("t3_expire", 0, 0, 0, 0, 1, 32'h80, 1, 0, 0, a_addr);
    step("t3_exit", 0, 0, 0, 0, 0, 0, 0, 0, 0, a_addr);

    // 4: FIRE stretched by halt, rstQnt seen in FIRE rearms on exit, stopQnt ignored
    step("t4_arm", 0, 0, 1, 0, 0, 0, 0, 1, 0, a_addr);
    retire_n("t4_ret", 99, 0, 0);
    a_addr = 32'hC0;
    step("t4_expire", 0, 0, 0, 0, 1, 32'hC0, 1, 0, 0, a_addr);
    step("t4_fire_h1", 0, 0, 1, 1, 1, 0, 1, 0, 0, a_addr);
    step("t4_fire_h2", 0, 1, 0, 1, 1, 0, 1, 0, 0, a_addr);
    step("t4_fire_h3", 0, 0, 0, 1, 0, 0, 1, 0, 0, a_addr);
    step("t4_exit_run", 0, 0, 0, 0, 0, 0, 0, 1, 0, a_addr);

    // 5: strobe coinciding with the expiring retire
    retire_n("t5_ret", 99, 0, 0);
    step("t5_rst_wins", 0, 0, 1, 0, 1, 32'h100, 0, 1, 0, a_addr);
    step("t5_no_int", 0, 0, 0, 0, 0, 0, 0, 1, 0, a_addr);
    retire_n("t5_ret2", 99, 0, 0);
    step("t5_stop_wins", 0, 1, 0, 0, 1, 32'h140, 0, 0, 99, a_addr);
    step("t5_no_int2", 0, 0, 0, 0, 0, 0, 0, 0, 99, a_addr);

    // table: strobe combinations from IDLE with count=99
    vecs[0]  = '{stop: 1, rq: 1, h: 0, iv: 0, ecnt: 0, erun: 0};
    vecs[1]  = '{stop: 0, rq: 0, h: 0, iv: 1, ecnt: 0, erun: 0};
    vecs[2]  = '{stop: 0, rq: 1, h: 0, iv: 0, ecnt: 0, erun: 1};
    vecs[3]  = '{stop: 0, rq: 0, h: 0, iv: 1, ecnt: 1, erun: 1};
    vecs[4]  = '{stop: 0, rq: 0, h: 1, iv: 1, ecnt: 1, erun: 1};
    vecs[5]  = '{stop: 0, rq: 0, h: 0, iv: 0, ecnt: 1, erun: 1};
    vecs[6]  = '{stop: 0, rq: 1, h: 0, iv: 1, ecnt: 0, erun: 1};
    vecs[7]  = '{stop: 0, rq: 0, h: 0, iv: 1, ecnt: 1, erun: 1};
    vecs[8]  = '{stop: 1, rq: 1, h: 0, iv: 1, ecnt: 0, erun: 0};
    vecs[9]  = '{stop: 0, rq: 1, h: 0, iv: 0, ecnt: 0, erun: 1};
    vecs[10] = '{stop: 1, rq: 0, h: 0, iv: 1, ecnt: 0, erun: 0};
    for (int i = 0; i < 11; i++)
      step($sformatf("tbl_%0d", i), 0, vecs[i].stop, vecs[i].rq, vecs[i].h, vecs[i].iv,
           ADDR_W'($urandom_range(0, 255)), 0, vecs[i].erun, vecs[i].ecnt, a_addr);

    // 6a: asynchronous reset in the middle of FIRE
    step("t6_arm", 0, 0, 1, 0, 0, 0, 0, 1, 0, a_addr);
    retire_n("t6_ret", 99, 0, 0);
    a_addr = 32'h1C0;
    step("t6_expire", 0, 0, 0, 0, 1, 32'h1C0, 1, 0, 0, a_addr);
    #2;
    rst = 1'b1;
    #1;
    a_addr = '0;
    check("t6_async_rst", sample(0), pack(0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    step("t6_post_rst", 0, 0, 0, 0, 1, 0, 0, 0, 0, a_addr);

    // 6b: QUANTUM=1 fires on the first retire and only rstQnt rearms
    step("q1_arm", 1, 0, 1, 0, 0, 0, 0, 1, 0, 0);
    step("q1_halted", 1, 0, 0, 1, 1, 32'h1FC, 0, 1, 0, 0);
    step("q1_expire", 1, 0, 0, 0, 1, 32'h200, 1, 0, 0, 32'h200);
    step("q1_exit", 1, 0, 0, 0, 1, 32'h204, 0, 0, 0, 32'h200);
    step("q1_no_rearm", 1, 0, 0, 0, 1, 32'h208, 0, 0, 0, 32'h200);
    step("q1_rearm", 1, 0, 1, 0, 0, 0, 0, 1, 0, 32'h200);
    step("q1_expire2", 1, 0, 0, 0, 1, 32'h20C, 1, 0, 0, 32'h20C);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL queue_drain: got %0d left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
